// File: rtl/szcv_flag_unit_if.sv
// -----------------------------------------------------------------------------
// szcv_flag_unit_if
//   Bundles the issue-stage, write-back and status signals of the SZCV flag
//   unit so the pipeline and the flag unit connect through a single port.
//
//   master : pipeline side. Drives issue/write-back/flush, observes status.
//   slave  : flag unit side. Receives issue/write-back/flush, drives status.
//
//   Issue      : iss_valid, iss_writes_flags, iss_is_branch, iss_cond[2:0]
//   Write-back : wb_valid, wb_szcv_src[1:0], alu_szcv[3:0], wb_data[DATA_W-1:0]
//   Control    : flush
//   Status     : flags[3:0] ({S,Z,C,V}), br_taken, br_stall, inflight_ovf
// -----------------------------------------------------------------------------
interface szcv_flag_unit_if #(
  parameter int DATA_W = 16
);
  logic              iss_valid;
  logic              iss_writes_flags;
  logic              iss_is_branch;
  logic [2:0]        iss_cond;
  logic              wb_valid;
  logic [1:0]        wb_szcv_src;
  logic [3:0]        alu_szcv;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [3:0]        flags;
  logic              br_taken;
  logic              br_stall;
  logic              inflight_ovf;

  modport master (
    output iss_valid, iss_writes_flags, iss_is_branch, iss_cond,
    output wb_valid, wb_szcv_src, alu_szcv, wb_data, flush,
    input  flags, br_taken, br_stall, inflight_ovf
  );

  modport slave (
    input  iss_valid, iss_writes_flags, iss_is_branch, iss_cond,
    input  wb_valid, wb_szcv_src, alu_szcv, wb_data, flush,
    output flags, br_taken, br_stall, inflight_ovf
  );
endinterface

// File: rtl/szcv_flag_unit.sv
// -----------------------------------------------------------------------------
// szcv_flag_unit
//   Architectural S/Z/C/V condition-flag register plus branch-condition
//   evaluator. Flags are committed at write-back from either the ALU flags or
//   the write-back data, selected by the 2-bit SZCVSrc. An occupancy counter
//   tracks in-flight flag writers; a conditional branch issued while writers
//   are outstanding is stalled until their flags are committed.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - szcv_flag_unit_if.slave (issue, write-back, flush, status)
//
//   Parameters:
//     DATA_W     - write-back data width (S/Z derivation for loads)
//     INFLIGHT_W - in-flight counter width (max 2^INFLIGHT_W-1 outstanding)
//
//   Optional feature (macro SZCV_BYPASS_EN):
//     Defined   - a same-cycle commit of the last outstanding writer releases
//                 the stall, and branches evaluate the next-state flags.
//     Undefined - branches see only registered flags; one extra stall cycle.
// -----------------------------------------------------------------------------
module szcv_flag_unit #(
  parameter int DATA_W     = 16,
  parameter int INFLIGHT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  szcv_flag_unit_if.slave bus
);

  localparam logic [INFLIGHT_W-1:0] CNT_MAX = '1;
  localparam logic [INFLIGHT_W-1:0] CNT_ONE = INFLIGHT_W'(1);

  // SZCVSrc encodings seen at write-back.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_RSVD = 2'b10,
    SRC_NONE = 2'b11
  } szcv_src_e;

  // Branch conditions; any code with bit 2 set is unconditional.
  typedef enum logic [1:0] {
    COND_BE  = 2'b00,
    COND_BLT = 2'b01,
    COND_BLE = 2'b10,
    COND_BNE = 2'b11
  } cond_e;

  logic [3:0]            flags_q, flags_d;
  logic [INFLIGHT_W-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic       commit;      // write-back updates flags this cycle
  logic       cnt_inc;
  logic       cnt_dec;
  logic       stall;
  logic       taken;
  logic [3:0] eval_flags;  // flags the branch condition is evaluated on
  szcv_src_e  src;
  cond_e      cond;

  assign src     = szcv_src_e'(bus.wb_szcv_src);
  assign cond    = cond_e'(bus.iss_cond[1:0]);
  assign commit  = bus.wb_valid & ~bus.flush;
  // Only SRC_ALU/SRC_LOAD writers were counted at issue.
  assign cnt_dec = bus.wb_valid & ~bus.wb_szcv_src[1];
  assign cnt_inc = bus.iss_valid & bus.iss_writes_flags & ~stall;

  // ---------------------------------------------------------------------------
  // Next-state flags
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves flags_d unassigned,
    // which would otherwise infer a latch.
    flags_d = flags_q;
    if (commit) begin
      unique case (src)
        SRC_ALU:  flags_d = bus.alu_szcv;
        SRC_LOAD: flags_d = {bus.wb_data[DATA_W-1], (bus.wb_data == '0), 2'b00};
        SRC_RSVD,
        SRC_NONE: flags_d = flags_q;
        default:  flags_d = flags_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight counter and sticky overflow. Flush dominates; a matched
  // increment/decrement pair cancels.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      if (cnt_q != '0)      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch hazard and condition evaluation
  // ---------------------------------------------------------------------------
`ifdef SZCV_BYPASS_EN
  // The last outstanding writer committing this cycle forwards its flags.
  assign stall = bus.iss_valid & bus.iss_is_branch & ~bus.iss_cond[2] &
                 (cnt_q != '0) &
                 ~(commit & ~bus.wb_szcv_src[1] & (cnt_q == CNT_ONE));
  assign eval_flags = flags_d;
`else
  assign stall = bus.iss_valid & bus.iss_is_branch & ~bus.iss_cond[2] &
                 (cnt_q != '0);
  assign eval_flags = flags_q;
`endif

  always_comb begin
    taken = 1'b0;
    if (bus.iss_is_branch && !stall) begin
      if (bus.iss_cond[2]) begin
        taken = 1'b1;
      end else begin
        // eval_flags = {S, Z, C, V}
        unique case (cond)
          COND_BE:  taken = eval_flags[2];
          COND_BLT: taken = eval_flags[3] ^ eval_flags[0];
          COND_BLE: taken = eval_flags[2] | (eval_flags[3] ^ eval_flags[0]);
          COND_BNE: taken = ~eval_flags[2];
          default:  taken = 1'b0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.br_stall     = stall;
  assign bus.br_taken     = taken;
  assign bus.inflight_ovf = ovf_q;

endmodule

// File: tb/tb_szcv_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_szcv_flag_unit
//   Self-checking bench for szcv_flag_unit. Directed scenarios cover reset,
//   ALU/load commits, the branch hazard, flush, simultaneous issue/commit and
//   saturation; a randomized phase compares every cycle against a behavioural
//   model (integer counter, flag vector) built from the unit's rules.
//   Expectations honour SZCV_BYPASS_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_szcv_flag_unit;

  localparam int DATA_W     = 16;
  localparam int INFLIGHT_W = 3;
  localparam int CNT_MAX    = (1 << INFLIGHT_W) - 1;

  logic clk;
  logic rst;

  szcv_flag_unit_if #(.DATA_W(DATA_W)) bus ();

  szcv_flag_unit #(.DATA_W(DATA_W), .INFLIGHT_W(INFLIGHT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int         m_cnt;
  logic [3:0] m_flags;
  logic       m_ovf;

  function automatic logic [3:0] m_next_flags();
    if (bus.wb_valid && !bus.flush) begin
      if (bus.wb_szcv_src == 2'b00) return bus.alu_szcv;
      if (bus.wb_szcv_src == 2'b01)
        return {bus.wb_data[DATA_W-1], (bus.wb_data == 0), 2'b00};
    end
    return m_flags;
  endfunction

  function automatic logic m_stall();
    logic s;
    s = bus.iss_valid && bus.iss_is_branch && !bus.iss_cond[2] && (m_cnt != 0);
`ifdef SZCV_BYPASS_EN
    if (m_cnt == 1 && bus.wb_valid && !bus.flush && !bus.wb_szcv_src[1]) s = 1'b0;
`endif
    return s;
  endfunction

  function automatic logic m_taken();
    logic [3:0] f;
    logic s_flag, z_flag, v_flag;
    if (!bus.iss_is_branch || m_stall()) return 1'b0;
    if (bus.iss_cond[2]) return 1'b1;
`ifdef SZCV_BYPASS_EN
    f = m_next_flags();
`else
    f = m_flags;
`endif
    s_flag = f[3]; z_flag = f[2]; v_flag = f[0];
    case (bus.iss_cond[1:0])
      2'd0:    return z_flag;
      2'd1:    return s_flag ^ v_flag;
      2'd2:    return z_flag | (s_flag ^ v_flag);
      default: return !z_flag;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_flags = 4'b0000; m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, settle 1 ns.
  task automatic drive(input logic iv, input logic wf, input logic br,
                       input logic [2:0] cond, input logic wv,
                       input logic [1:0] src, input logic [3:0] alu,
                       input logic [DATA_W-1:0] data, input logic fl);
    @(negedge clk);
    bus.iss_valid = iv; bus.iss_writes_flags = wf; bus.iss_is_branch = br;
    bus.iss_cond = cond; bus.wb_valid = wv; bus.wb_szcv_src = src;
    bus.alu_szcv = alu; bus.wb_data = data; bus.flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
  endtask

  // Advance model and DUT across one rising edge using the current inputs.
  task automatic advance();
    logic [3:0] nf;
    logic inc, dec;
    int nc;
    logic no;
    nf  = m_next_flags();
    inc = bus.iss_valid && bus.iss_writes_flags && !m_stall();
    dec = bus.wb_valid && !bus.wb_szcv_src[1];
    nc  = m_cnt;
    no  = m_ovf;
    if (bus.flush) nc = 0;
    else if (inc && !dec) begin
      if (m_cnt == CNT_MAX) no = 1'b1; else nc = m_cnt + 1;
    end else if (dec && !inc) begin
      if (m_cnt > 0) nc = m_cnt - 1;
    end
    @(posedge clk);
    m_flags = nf; m_cnt = nc; m_ovf = no;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 1, 3'b001, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.inflight_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.inflight_ovf); end
    model_reset();
    idle();
    rst = 1'b0;
    advance();
  endtask

  task automatic test_alu_commit();
    drive(0, 0, 0, 3'b000, 1, 2'b00, 4'b0100, '0, 0);
    advance();
    drive(1, 0, 1, 3'b000, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL alu_flags got=%b exp=0100", bus.flags); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL alu_be_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL alu_be_taken got=%b exp=1", bus.br_taken); end
    advance();
  endtask

  task automatic test_load_commit();
    drive(0, 0, 0, 3'b000, 1, 2'b01, 4'b1111, 16'h8000, 0);
    advance();
    drive(0, 0, 0, 3'b000, 1, 2'b01, 4'b1111, 16'h0000, 0);
    checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL load_neg got=%b exp=1000", bus.flags); end
    advance();
    drive(0, 0, 0, 3'b000, 1, 2'b11, 4'b1111, 16'h1234, 0);
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL load_zero got=%b exp=0100", bus.flags); end
    advance();
    drive(0, 0, 0, 3'b000, 1, 2'b10, 4'b1011, 16'h8001, 0);
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL store_hold got=%b exp=0100", bus.flags); end
    advance();
    drive(1, 0, 1, 3'b011, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL rsvd_hold got=%b exp=0100", bus.flags); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got=%b exp=0", bus.br_taken); end
    advance();
  endtask

  task automatic test_hazard();
    drive(1, 1, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
    advance();
    drive(1, 0, 1, 3'b001, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL hazard_stall got=%b exp=1", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL hazard_taken got=%b exp=0", bus.br_taken); end
    advance();
    drive(1, 0, 1, 3'b001, 1, 2'b00, 4'b1000, '0, 0);
`ifdef SZCV_BYPASS_EN
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL commit_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL commit_taken got=%b exp=1", bus.br_taken); end
`else
    checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL commit_stall got=%b exp=1", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL commit_taken got=%b exp=0", bus.br_taken); end
`endif
    advance();
    drive(1, 0, 1, 3'b001, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL resolve_flags got=%b exp=1000", bus.flags); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL resolve_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL resolve_taken got=%b exp=1", bus.br_taken); end
    advance();
  endtask

  task automatic test_flush_simultaneous();
    drive(1, 1, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
    advance();
    drive(1, 1, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
    advance();
    // counter 2: issue and commit together
    drive(1, 1, 0, 3'b000, 1, 2'b00, 4'b0011, '0, 0);
    advance();
    // counter still 2: one commit, stall remains even with bypass
    drive(1, 0, 1, 3'b001, 1, 2'b00, 4'b0011, '0, 0);
    checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL simul_stall got=%b exp=1", bus.br_stall); end
    advance();
    // counter 1: flush with a write-back that must not commit
    drive(1, 0, 1, 3'b001, 1, 2'b00, 4'b1111, '0, 1);
    checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall got=%b exp=1", bus.br_stall); end
    checks++; if (bus.flags !== 4'b0011) begin errors++; $display("FAIL pre_flush_flags got=%b exp=0011", bus.flags); end
    advance();
    drive(1, 0, 1, 3'b010, 0, 2'b11, 4'h0, '0, 0);
    checks++; if (bus.flags !== 4'b0011) begin errors++; $display("FAIL flush_flags got=%b exp=0011", bus.flags); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL flush_cnt_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL flush_ble_taken got=%b exp=1", bus.br_taken); end
    advance();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      drive(1, 1, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
      checks++; if (bus.inflight_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_early i=%0d got=%b exp=0", i, bus.inflight_ovf); end
      advance();
    end
    // Drain seven writers; the stall must persist until the last one.
    for (int i = 0; i < CNT_MAX; i++) begin
      drive(1, 0, 1, 3'b000, 1, 2'b00, 4'b1010, '0, 0);
      checks++; if (bus.inflight_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf i=%0d got=%b exp=1", i, bus.inflight_ovf); end
`ifdef SZCV_BYPASS_EN
      checks++; if (bus.br_stall !== (i != CNT_MAX - 1)) begin errors++; $display("FAIL sat_drain_stall i=%0d got=%b exp=%b", i, bus.br_stall, (i != CNT_MAX - 1)); end
`else
      checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL sat_drain_stall i=%0d got=%b exp=1", i, bus.br_stall); end
`endif
      advance();
    end
    drive(1, 0, 1, 3'b000, 0, 2'b11, 4'h0, '0, 1);
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL sat_drained_stall got=%b exp=0", bus.br_stall); end
    advance();
    idle();
    checks++; if (bus.inflight_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=1", bus.inflight_ovf); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 3'b000, 0, 2'b11, 4'h0, '0, 0);
    advance();
    drive(1, 0, 1, 3'b001, 1, 2'b00, 4'b0110, '0, 0);
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got=%b exp=0000", bus.flags); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.br_stall); end
    checks++; if (bus.inflight_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", bus.inflight_ovf); end
    @(posedge clk);
    model_reset();
    idle();
    rst = 1'b0;
    advance();
    idle();
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rstmid_no_commit got=%b exp=0000", bus.flags); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            logic'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            4'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            logic'($urandom_range(0, 24) == 0));
      checks++; if (bus.flags !== m_flags) begin errors++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, bus.flags, m_flags); end
      checks++; if (bus.br_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.br_stall, m_stall()); end
      checks++; if (bus.br_taken !== m_taken()) begin errors++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, bus.br_taken, m_taken()); end
      checks++; if (bus.inflight_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, bus.inflight_ovf, m_ovf); end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.iss_valid = 1'b0; bus.iss_writes_flags = 1'b0; bus.iss_is_branch = 1'b0;
    bus.iss_cond = 3'b000; bus.wb_valid = 1'b0; bus.wb_szcv_src = 2'b11;
    bus.alu_szcv = 4'h0; bus.wb_data = '0; bus.flush = 1'b0;
    model_reset();
    test_reset();
    test_alu_commit();
    test_load_commit();
    test_hazard();
    test_flush_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/szcv_flag_unit.md
Name: szcv_flag_unit

Overview:
- Architectural S/Z/C/V condition-flag register plus branch-condition evaluator.
- Sits directly downstream of the SZCV source decoder. Consumes its 2-bit SZCVSrc select at write-back and commits flags from either the ALU or the write-back data.
- Tracks in-flight flag writers with an occupancy counter. Raises a branch hazard stall until the flags a pending branch needs are committed.

Parameters:
- DATA_W, 16, width of write-back data used for S/Z derivation.
- INFLIGHT_W, 3, width of in-flight flag-writer counter (max 2^INFLIGHT_W-1 outstanding).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- iss_valid  input  1  an instruction issues this cycle.
- iss_writes_flags  input  1  the issuing instruction will write flags (SZCVSrc != 2'b11 at issue).
- iss_is_branch  input  1  the issuing instruction is a conditional branch.
- iss_cond  input  3  branch condition: 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (~Z), 1xx always taken.
- wb_valid  input  1  an instruction commits this cycle.
- wb_szcv_src  input  2  SZCVSrc of the committing instruction.
- alu_szcv  input  4  ALU flags {S,Z,C,V} of the committing instruction.
- wb_data  input  DATA_W  write-back data of the committing instruction.
- flush  input  1  squash all in-flight instructions.
- flags  output  4  committed {S,Z,C,V}.
- br_taken  output  1  evaluated branch condition for the issuing branch.
- br_stall  output  1  hold issue: branch needs flags still in flight.
- inflight_ovf  output  1  sticky error: issue attempted with counter saturated.

Behaviour:
- Reset (async, rst=1): flags=4'b0000, counter=0, inflight_ovf=0. br_taken=0 and br_stall=0 follow from the reset state.
- Flag commit (registered, 1-cycle latency to flags) on wb_valid & ~flush, selected by wb_szcv_src:
  - 00 ALU op: flags<=alu_szcv.
  - 01 LD/IN: S<=wb_data[DATA_W-1]; Z<=(wb_data==0); C<=0; V<=0.
  - 11 ST/OUT: flags unchanged.
  - 10 reserved: flags unchanged.
- Counter increments on iss_valid & iss_writes_flags & ~br_stall.
- Counter decrements on wb_valid & (wb_szcv_src[1]==0).
- Simultaneous increment and decrement: counter unchanged.
- flush: counter<=0 next cycle. Flags are not committed from that cycle's write-back. Flush wins over every other event.
- Saturation: an increment while the counter is at its maximum leaves the counter unchanged and sets inflight_ovf (sticky until rst).
- Underflow: a decrement at 0 holds the counter at 0.
- br_stall (combinational) = iss_valid & iss_is_branch & ~iss_cond[2] & (counter!=0).
- br_taken (combinational):
  - Evaluated from the committed flags per iss_cond.
  - Forced to 0 when br_stall=1 or iss_is_branch=0.
  - Forced to 1 for iss_cond=1xx when iss_is_branch=1.
- Reset mid-operation: all state clears immediately. No pending commit survives.

Optional Feature:
- Macro: SZCV_BYPASS_EN.
- Defined:
  - Same-cycle commit is forwarded into branch evaluation. If wb_valid & ~flush & wb_szcv_src[1]==0 and counter==1, br_stall=0.
  - br_taken uses the next-state flags.
- Undefined: no forwarding. The branch stalls one extra cycle and sees the flags once registered.

Test Plan:
1. Reset: assert rst mid-cycle -> flags=0000, br_stall=0, inflight_ovf=0 immediately, without waiting for clk.
2. ALU commit: wb_valid=1, wb_szcv_src=00, alu_szcv=4'b0100 -> next cycle flags=0100; then issue BE (iss_cond=000) with counter 0 -> br_taken=1, br_stall=0.
3. Load commit: wb_szcv_src=01, wb_data=16'h8000 -> flags=1000; wb_data=16'h0000 -> flags=0100; wb_szcv_src=11 -> flags hold.
4. Hazard: issue a flag writer (counter 0->1), next cycle issue BLT -> br_stall=1, br_taken=0.
   - Commit with alu_szcv=1000: BLT resolves taken (S^V=1) next cycle without SZCV_BYPASS_EN, or in the commit cycle with it.
5. Flush/simultaneous: counter=2, same-cycle issue and commit -> counter stays 2; assert flush -> counter 0 and flags unchanged despite wb_valid=1.
6. Saturation: issue 8 flag writers with no commits (INFLIGHT_W=3) -> counter stops at 7, inflight_ovf=1 and stays 1 until rst.
